// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// pipe_hazard_ctrl: LEGv8 5-stage pipeline sequencer for load-use stalls, branch flushes and memory freeze.
// Rev 1.0 - memory timeout trap and saturating stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_rm,
  input  logic             id_uses_rm,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_br_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             pipe_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_q, flush_q;

  logic mstall;
  logic load_use;
  logic pc_en_w, ifid_en_w, pipe_en_w, ifid_flush_w, idex_flush_w;

  assign mstall   = mem_req & ~mem_ready;
  // XZR reads as zero regardless of any in-flight load, so it can never hazard.
  assign load_use = ex_memread & (ex_rd != 5'd31) &
                    ((ex_rd == id_rn) | (id_uses_rm & (ex_rd == id_rm)));

  always_comb begin
    pc_en_w      = 1'b0;
    ifid_en_w    = 1'b0;
    pipe_en_w    = 1'b0;
    ifid_flush_w = 1'b0;
    idex_flush_w = 1'b0;
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;

    case (state_q)
      RUN, MEM_WAIT: begin
        // Memory freeze outranks a resolved branch; the branch stays in EX until release.
        if (mstall) begin
          pc_en_w   = 1'b0;
          ifid_en_w = 1'b0;
          pipe_en_w = 1'b0;
        end else if (ex_br_taken) begin
          pc_en_w      = 1'b1;
          ifid_en_w    = 1'b1;
          pipe_en_w    = 1'b1;
          ifid_flush_w = 1'b1;
          idex_flush_w = 1'b1;
        end else if (load_use) begin
          pipe_en_w    = 1'b1;
          idex_flush_w = 1'b1;
        end else begin
          pc_en_w   = 1'b1;
          ifid_en_w = 1'b1;
          pipe_en_w = 1'b1;
        end

        if (state_q == RUN) begin
          if (mstall) begin
            state_d    = MEM_WAIT;
            wait_cnt_d = WCW'(1);
          end
        end else begin
          if (!mstall) begin
            state_d    = RUN;
            wait_cnt_d = '0;
          end else if (wait_cnt_q == WAIT_LAST) begin
            state_d    = ERR;
            wait_cnt_d = '0;
          end else begin
            wait_cnt_d = wait_cnt_q + WCW'(1);
          end
        end
      end
      ERR: begin
        state_d    = ERR;
        wait_cnt_d = '0;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      stall_q    <= '0;
      flush_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (!pc_en_w && (stall_q != CNT_MAX)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (ifid_flush_w && (flush_q != CNT_MAX)) begin
        flush_q <= flush_q + CNT_W'(1);
      end
    end
  end

  // Hold the whole pipe quiet while reset is asserted.
  assign pc_en        = rst_n & pc_en_w;
  assign ifid_en      = rst_n & ifid_en_w;
  assign pipe_en      = rst_n & pipe_en_w;
  assign ifid_flush   = rst_n & ifid_flush_w;
  assign idex_flush   = rst_n & idex_flush_w;
  assign err          = (state_q == ERR);
  assign stall_cycles = stall_q;
  assign flush_events = flush_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// tb_pipe_hazard_ctrl: directed bench for pipe_hazard_ctrl, default instance plus a CNT_W=4 instance.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] id_rn, id_rm, ex_rd;
  logic id_uses_rm, ex_memread, ex_br_taken, mem_req, mem_ready;

  logic pc_en, ifid_en, pipe_en, ifid_flush, idex_flush, err;
  logic [15:0] stall_cycles, flush_events;
  logic pc_en4, ifid_en4, pipe_en4, ifid_flush4, idex_flush4, err4;
  logic [3:0] stall4, flush4;

  wire [4:0] strb  = {pc_en, ifid_en, pipe_en, ifid_flush, idex_flush};
  wire [4:0] strb4 = {pc_en4, ifid_en4, pipe_en4, ifid_flush4, idex_flush4};

  int total = 0;
  int bad   = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_rn(id_rn), .id_rm(id_rm), .id_uses_rm(id_uses_rm),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_br_taken(ex_br_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_en(pc_en), .ifid_en(ifid_en),
    .pipe_en(pipe_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush), .err(err),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  pipe_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .id_rn(id_rn), .id_rm(id_rm), .id_uses_rm(id_uses_rm),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_br_taken(ex_br_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_en(pc_en4), .ifid_en(ifid_en4),
    .pipe_en(pipe_en4), .ifid_flush(ifid_flush4), .idex_flush(idex_flush4), .err(err4),
    .stall_cycles(stall4), .flush_events(flush4)
  );

  task automatic idle();
    id_rn = 5'd1; id_rm = 5'd3; id_uses_rm = 1'b0; ex_rd = 5'd7;
    ex_memread = 1'b0; ex_br_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    total++; if (strb !== 5'b00000) begin bad++; $display("FAIL rst_strobes got=%b want=00000", strb); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", err); end
    total++; if (stall_cycles !== 16'd0 || flush_events !== 16'd0) begin bad++;
      $display("FAIL rst_counters got=%0d/%0d want=0/0", stall_cycles, flush_events); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (strb !== 5'b11100) begin bad++; $display("FAIL rst_release got=%b want=11100", strb); end
    tick();
  endtask

  task automatic test_load_use();
    ex_rd = 5'd2; ex_memread = 1'b1; id_rn = 5'd2;
    #1;
    total++; if (strb !== 5'b00101) begin bad++; $display("FAIL lu_rn_strobes got=%b want=00101", strb); end
    tick(); exp_stall++;
    ex_memread = 1'b0;
    #1;
    total++; if (strb !== 5'b11100) begin bad++; $display("FAIL lu_after got=%b want=11100", strb); end
    total++; if (stall_cycles !== 16'(exp_stall)) begin bad++;
      $display("FAIL lu_stall got=%0d want=%0d", stall_cycles, exp_stall); end
    ex_memread = 1'b1; id_rn = 5'd5; id_rm = 5'd2; id_uses_rm = 1'b1;
    #1;
    total++; if (strb !== 5'b00101) begin bad++; $display("FAIL lu_rm_strobes got=%b want=00101", strb); end
    tick(); exp_stall++;
    idle();
  endtask

  task automatic test_no_hazard();
    ex_memread = 1'b1; ex_rd = 5'd31; id_rn = 5'd31;
    #1;
    total++; if (strb !== 5'b11100) begin bad++; $display("FAIL nh_xzr got=%b want=11100", strb); end
    tick();
    ex_rd = 5'd2; id_rn = 5'd4; id_rm = 5'd2; id_uses_rm = 1'b0;
    #1;
    total++; if (strb !== 5'b11100) begin bad++; $display("FAIL nh_rm_unused got=%b want=11100", strb); end
    tick();
    ex_memread = 1'b0; id_rn = 5'd2;
    #1;
    total++; if (strb !== 5'b11100) begin bad++; $display("FAIL nh_not_load got=%b want=11100", strb); end
    tick();
    total++; if (stall_cycles !== 16'(exp_stall)) begin bad++;
      $display("FAIL nh_stall got=%0d want=%0d", stall_cycles, exp_stall); end
    idle();
  endtask

  task automatic test_branch();
    ex_br_taken = 1'b1; ex_memread = 1'b1; ex_rd = 5'd9; id_rn = 5'd9;
    #1;
    total++; if (strb !== 5'b11111) begin bad++; $display("FAIL br_strobes got=%b want=11111", strb); end
    tick(); exp_flush++;
    idle();
    #1;
    total++; if (flush_events !== 16'(exp_flush) || stall_cycles !== 16'(exp_stall)) begin bad++;
      $display("FAIL br_counters got=%0d/%0d want=%0d/%0d", flush_events, stall_cycles, exp_flush, exp_stall); end
  endtask

  task automatic test_mem_stall();
    mem_req = 1'b1; mem_ready = 1'b0; ex_br_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (strb !== 5'b00000) begin bad++; $display("FAIL ms_frozen%0d got=%b want=00000", i, strb); end
      tick(); exp_stall++;
    end
    mem_ready = 1'b1;
    #1;
    total++; if (strb !== 5'b11111) begin bad++; $display("FAIL ms_release got=%b want=11111", strb); end
    tick(); exp_flush++;
    ex_br_taken = 1'b0;
    #1;
    total++; if (strb !== 5'b11100) begin bad++; $display("FAIL ms_single got=%b want=11100", strb); end
    total++; if (stall_cycles !== 16'(exp_stall) || flush_events !== 16'(exp_flush)) begin bad++;
      $display("FAIL ms_counters got=%0d/%0d want=%0d/%0d", stall_cycles, flush_events, exp_stall, exp_flush); end
    tick();
    mem_ready = 1'b0;
    tick(); exp_stall++;
    mem_req = 1'b0;
    #1;
    total++; if (strb !== 5'b11100) begin bad++; $display("FAIL ms_req_drop got=%b want=11100", strb); end
    tick();
    total++; if (stall_cycles !== 16'(exp_stall)) begin bad++;
      $display("FAIL ms_stall got=%0d want=%0d", stall_cycles, exp_stall); end
  endtask

  task automatic test_timeout();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      total++; if (err !== 1'b0 || strb !== 5'b00000) begin bad++;
        $display("FAIL to_wait%0d got=err%b/%b want=err0/00000", i, err, strb); end
      tick(); exp_stall++;
    end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL to_err got=%b want=1", err); end
    mem_req = 1'b0; mem_ready = 1'b1; ex_br_taken = 1'b1;
    #1;
    total++; if (strb !== 5'b00000) begin bad++; $display("FAIL to_err_strobes got=%b want=00000", strb); end
    repeat (2) begin tick(); exp_stall++; end
    total++; if (err !== 1'b1 || stall_cycles !== 16'(exp_stall)) begin bad++;
      $display("FAIL to_sticky got=err%b/%0d want=err1/%0d", err, stall_cycles, exp_stall); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL to_rst_err got=%b want=0", err); end
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    exp_stall = 0; exp_flush = 0;
    #1;
    total++; if (strb !== 5'b11100 || err !== 1'b0) begin bad++;
      $display("FAIL to_run_after got=err%b/%b want=err0/11100", err, strb); end
    tick();
  endtask

  task automatic test_saturate();
    ex_memread = 1'b1; ex_rd = 5'd4; id_rn = 5'd4;
    repeat (20) begin tick(); exp_stall++; end
    total++; if (stall4 !== 4'd15) begin bad++; $display("FAIL sat_stall4 got=%0d want=15", stall4); end
    total++; if (stall_cycles !== 16'(exp_stall)) begin bad++;
      $display("FAIL sat_stall16 got=%0d want=%0d", stall_cycles, exp_stall); end
    idle();
    ex_br_taken = 1'b1;
    repeat (20) begin tick(); exp_flush++; end
    total++; if (flush4 !== 4'd15 || flush_events !== 16'(exp_flush)) begin bad++;
      $display("FAIL sat_flush got=%0d/%0d want=15/%0d", flush4, flush_events, exp_flush); end
    idle();
    mem_req = 1'b1;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (stall_cycles !== 16'd0 || flush_events !== 16'd0 || stall4 !== 4'd0 || flush4 !== 4'd0) begin bad++;
      $display("FAIL rst_mid_counters got=%0d/%0d/%0d/%0d want=0/0/0/0", stall_cycles, flush_events, stall4, flush4); end
    total++; if (strb !== 5'b00000 || strb4 !== 5'b00000) begin bad++;
      $display("FAIL rst_mid_strobes got=%b/%b want=00000/00000", strb, strb4); end
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    #1;
    total++; if (strb !== 5'b11100 || strb4 !== 5'b11100 || err4 !== 1'b0) begin bad++;
      $display("FAIL rst_mid_run got=%b/%b err4=%b want=11100/11100 err4=0", strb, strb4, err4); end
    tick();
    total++; if (stall_cycles !== 16'd0) begin bad++; $display("FAIL rst_mid_stall got=%0d want=0", stall_cycles); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_branch();
    test_mem_stall();
    test_timeout();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
